uart_baud_gen_os: RTL

//  Runtime-programmable UART baud generator with oversampling and optional fractional divide.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_frac_acc.sv | 28 ++
 rtl/uart_baud_gen_os.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and reset-divisor helper
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;

  // Integer clocks per os_tick for a given clock, baud and oversample ratio
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// rtl/uart_frac_acc.sv - fractional divisor accumulator; carry stretches the next os period by one clock
module uart_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac};

  // Accumulate once per os period; the carry is held for the whole following period
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      {carry, acc} <= sum;
    end
  end

endmodule

// File: rtl/uart_baud_gen_os.sv
// rtl/uart_baud_gen_os.sv - oversampling UART baud generator; UART_BAUD_FRAC_EN enables fractional divide
module uart_baud_gen_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DEF_BAUD   = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  output logic                          div_pend,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(baud_div(CLK_FREQ, DEF_BAUD, OVERSAMPLE));

  logic [DIV_W-1:0] act_int, sh_int;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W:0]   period;
  logic             run;
  logic             carry;
  logic             eop, wrap;
  logic             take_direct, take_shadow, capture;
  logic             acc_clr;

  // run is low on the first enabled cycle so the first period is one clock longer
  assign period      = ((act_int < DIV_W'(2)) ? (DIV_W+1)'(2) : {1'b0, act_int}) + (DIV_W+1)'(carry);
  assign eop         = en && run && ({1'b0, cnt} == period - (DIV_W+1)'(1));
  assign wrap        = eop && (os_phase == PH_W'(OVERSAMPLE - 1));
  assign take_direct = !en && div_load;
  assign take_shadow = div_pend && ((!en && !div_load) || wrap);
  assign capture     = en && div_load;
  assign acc_clr     = !en || (wrap && div_pend);

  // Period counter, os/bit tick generation and phase tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      run      <= 1'b0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      run      <= en;
      os_tick  <= eop;
      bit_tick <= wrap;
      if (!en) begin
        cnt      <= '0;
        os_phase <= '0;
      end else if (eop) begin
        cnt      <= '0;
        os_phase <= os_phase + 1'b1;
      end else if (run) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadow/active integer divisor: a load made while running waits for a bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      act_int  <= RST_DIV;
      sh_int   <= RST_DIV;
      div_pend <= 1'b0;
    end else begin
      if (take_direct) begin
        act_int <= div_int;
        sh_int  <= div_int;
      end else if (take_shadow) begin
        act_int <= sh_int;
      end
      if (capture) begin
        sh_int   <= div_int;
        div_pend <= 1'b1;
      end else if (take_shadow || !en) begin
        div_pend <= 1'b0;
      end
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] act_frac, sh_frac;

  // Fractional divisor follows the same shadow/apply rules as the integer part
  always_ff @(posedge clk) begin
    if (rst) begin
      act_frac <= '0;
      sh_frac  <= '0;
    end else begin
      if (take_direct) begin
        act_frac <= div_frac;
        sh_frac  <= div_frac;
      end else if (take_shadow) begin
        act_frac <= sh_frac;
      end
      if (capture) sh_frac <= div_frac;
    end
  end

  uart_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .step  (eop),
    .frac  (act_frac),
    .carry (carry)
  );
`else
  logic unused_frac;
  assign unused_frac = ^{div_frac, acc_clr};
  assign carry       = 1'b0;
`endif

endmodule
